// File: rtl/return_stack_pkg.sv
// Shared definitions for the return-address stack.
//   ST_STAGE      : pipeline stage index the push/pop requests come from
//   rs_state_t    : control FSM encoding (RUN=0, HALT=1)
//   DEFAULT_AW    : default return-address width
//   DEFAULT_DEPTH : default number of stack entries
package return_stack_pkg;

  localparam int ST_STAGE      = 5;
  localparam int DEFAULT_AW    = 16;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } rs_state_t;

endpackage

// File: rtl/return_stack_ram.sv
// Entry storage for the return stack: one synchronous write port and one
// combinational read port. No reset; unread entries are never observable
// because the controller only reads below the current occupancy.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : combinational read data
module stack_ram #(
  parameter int DEPTH = return_stack_pkg::DEFAULT_DEPTH,
  parameter int AW    = return_stack_pkg::DEFAULT_AW,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Hardware return-address stack with RUN/HALT control.
// Handshake: a request is a single-cycle level on st_w (push) and/or st_r
// (pop); there is no ready, a request is either executed at the next rising
// edge or turned into an overflow/underflow event that halts the stack.
// A successful pop returns its data one cycle later with a one-cycle
// pop_valid pulse.
//   clk, rst_n          : clock, async active-low reset
//   st_w, st_r          : push / pop requests
//   push_data           : address to push
//   clr_err             : clears sticky errors, returns to RUN, masks requests
//   pop_data, pop_valid : registered pop result and its qualifier
//   full, empty, count  : occupancy
//   overflow, underflow : sticky error flags
//   halted              : FSM is in HALT
//   fsm_state           : raw FSM state for observation
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_w,
  input  logic                     st_r,
  input  logic [AW-1:0]            push_data,
  input  logic                     clr_err,
  output logic [AW-1:0]            pop_data,
  output logic                     pop_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     halted,
  output rs_state_t                fsm_state
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  rs_state_t     state;
  logic          active;
  logic          do_push, do_pop, do_swap, ovf_ev, udf_ev;
  logic          ram_we;
  logic [IW-1:0] wr_idx, top_idx;
  logic [AW-1:0] top_data;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign halted    = (state == HALT);
  assign fsm_state = state;

  // clr_err masks every request in its cycle, in either state.
  assign active  = (state == RUN) && !clr_err;
  assign do_push = active && st_w && !st_r && !full;
  assign do_pop  = active && st_r && !st_w && !empty;
  assign do_swap = active && st_r && st_w && !empty;
  assign ovf_ev  = active && st_w && !st_r && full;
  // A simultaneous push+pop on an empty stack counts as a plain underflow.
  assign udf_ev  = active && st_r && empty;

  // Index arithmetic is truncated to the RAM width; top_idx is only used
  // when count>0 and wr_idx only when count<DEPTH, so no wrap is observable.
  assign top_idx = IW'(count - CW'(1));
  assign wr_idx  = do_swap ? top_idx : IW'(count);
  assign ram_we  = do_push || do_swap;

  stack_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_idx),
    .wdata (push_data),
    .raddr (top_idx),
    .rdata (top_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
        state     <= RUN;
      end else if (state == RUN) begin
        if (udf_ev) begin
          underflow <= 1'b1;
          state     <= HALT;
        end else if (ovf_ev) begin
          overflow <= 1'b1;
          state    <= HALT;
        end else if (do_pop) begin
          pop_data  <= top_data;
          pop_valid <= 1'b1;
          count     <= count - CW'(1);
        end else if (do_swap) begin
          // Old top leaves on pop_data while the RAM overwrites it in place.
          pop_data  <= top_data;
          pop_valid <= 1'b1;
        end else if (do_push) begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_return_stack.sv
module tb_return_stack;
  import return_stack_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            st_w = 1'b0;
  logic            st_r = 1'b0;
  logic [AW-1:0]   push_data = '0;
  logic            clr_err = 1'b0;
  logic [AW-1:0]   pop_data;
  logic            pop_valid;
  logic            full, empty;
  logic [3:0]      count;
  logic            overflow, underflow, halted;
  rs_state_t       fsm_state;

  int vectors = 0;
  int miscompares = 0;

  // clock / reset
  always #5 clk = ~clk;

  return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_w      (st_w),
    .st_r      (st_r),
    .push_data (push_data),
    .clr_err   (clr_err),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .halted    (halted),
    .fsm_state (fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] d);
    st_w = 1'b1; push_data = d;
    step();
    st_w = 1'b0;
  endtask

  task automatic pop();
    st_r = 1'b1;
    step();
    st_r = 1'b0;
  endtask

  task automatic clear();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    chk("rst_pop_data", 32'(pop_data), 0);
    chk("rst_flags", {30'b0, overflow, underflow}, 0);
    chk("rst_halted", 32'(halted), 0);
    step();
    rst_n = 1'b1;
    step();

    // LIFO order, one-cycle pop latency
    push(16'h0010); push(16'h0020); push(16'h0030);
    chk("lifo_count3", 32'(count), 3);
    pop();
    chk("lifo_pv1", 32'(pop_valid), 1);
    chk("lifo_pd1", 32'(pop_data), 32'h30);
    chk("lifo_cnt_after1", 32'(count), 2);
    step();
    chk("lifo_pv_drop", 32'(pop_valid), 0);
    pop();
    chk("lifo_pd2", 32'(pop_data), 32'h20);
    pop();
    chk("lifo_pd3", {31'b0, pop_valid} << 16 | 32'(pop_data), 32'h10010);
    chk("lifo_empty", 32'(empty), 1);
    chk("lifo_count0", 32'(count), 0);

    // simultaneous push+pop replaces the top
    push(16'h0022); push(16'h0033); push(16'h0044);
    st_w = 1'b1; st_r = 1'b1; push_data = 16'h0055;
    step();
    st_w = 1'b0; st_r = 1'b0;
    chk("swap_pd", 32'(pop_data), 32'h44);
    chk("swap_pv", 32'(pop_valid), 1);
    chk("swap_count", 32'(count), 3);
    pop();
    chk("swap_new_top", 32'(pop_data), 32'h55);
    pop();
    chk("swap_below", 32'(pop_data), 32'h33);
    pop();
    chk("swap_bottom", 32'(pop_data), 32'h22);

    // overflow on the ninth push
    for (int i = 0; i < DEPTH; i++) push(16'h0100 + 16'(i));
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf_clear", 32'(overflow), 0);
    push(16'hBEEF);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_halted", 32'(halted), 1);
    chk("ovf_state", 32'(fsm_state), 32'(HALT));
    chk("ovf_count", 32'(count), 8);
    chk("ovf_full", 32'(full), 1);
    pop();
    chk("halt_pop_pv", 32'(pop_valid), 0);
    chk("halt_pop_count", 32'(count), 8);
    clear();
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_halted", 32'(halted), 0);
    chk("clr_count", 32'(count), 8);
    pop();
    chk("clr_pop_pv", 32'(pop_valid), 1);
    chk("clr_pop_pd", 32'(pop_data), 32'h107);
    chk("clr_pop_count", 32'(count), 7);

    // underflow right after reset
    rst_n = 1'b0;
    #2;
    chk("rst2_count", 32'(count), 0);
    chk("rst2_pd", 32'(pop_data), 0);
    step();
    rst_n = 1'b1;
    step();
    pop();
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_halted", 32'(halted), 1);
    chk("udf_pv", 32'(pop_valid), 0);
    chk("udf_pd", 32'(pop_data), 0);
    push(16'h0abc);
    chk("halt_push_count", 32'(count), 0);
    clear();
    chk("udf_cleared", {30'b0, underflow, halted}, 0);

    // clr_err masks a push in the same cycle
    st_w = 1'b1; push_data = 16'h0777; clr_err = 1'b1;
    step();
    st_w = 1'b0; clr_err = 1'b0;
    chk("clr_mask_push", 32'(count), 0);

    // push+pop on empty is an underflow
    st_w = 1'b1; st_r = 1'b1; push_data = 16'h0999;
    step();
    st_w = 1'b0; st_r = 1'b0;
    chk("swap_empty_udf", 32'(underflow), 1);
    chk("swap_empty_count", 32'(count), 0);
    chk("swap_empty_pv", 32'(pop_valid), 0);
    clear();

    // reset in the same cycle as a pop request
    push(16'h00a1); push(16'h00a2);
    st_r = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstpop_count", 32'(count), 0);
    chk("rstpop_pv", 32'(pop_valid), 0);
    chk("rstpop_empty", 32'(empty), 1);
    step();
    st_r = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstpop_no_pulse", 32'(pop_valid), 0);
    end
    chk("rstpop_flags", {30'b0, underflow, overflow}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
